// File: rtl/seg7_decode_onehot_if.sv
// Segment-bus bundle between a 7-segment source and the decoder.
// Latency: none (wires only).
// Backpressure: none; en is a sample-enable, not a handshake.
// Ports: h/en are driven by the source (master); code/y/valid/blank/err/changed
// (+ err_cnt when SEG7_DEC_ERRCNT_EN is defined) are driven by the decoder (slave).
interface seg7_decode_onehot_if;
  logic [6:0] h;        // segment pattern {g,f,e,d,c,b,a}
  logic       en;       // sample enable
  logic [2:0] code;     // committed digit value
  logic [7:0] y;        // one-hot of code when valid
  logic       valid;
  logic       blank;
  logic       err;
  logic       changed;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_cnt;  // count of entries into the fault class

  modport master (output h, en,
                  input  code, y, valid, blank, err, changed, err_cnt);
  modport slave  (input  h, en,
                  output code, y, valid, blank, err, changed, err_cnt);
`else
  modport master (output h, en,
                  input  code, y, valid, blank, err, changed);
  modport slave  (input  h, en,
                  output code, y, valid, blank, err, changed);
`endif
endinterface

// File: rtl/seg7_decode_onehot.sv
// Debounce a sampled 7-seg pattern, decode it to a 3-bit code + one-hot, flag blank/illegal.
// Latency: a pattern held with en=1 reaches the outputs on the (STABLE_CYCLES+1)th sampling edge.
// Backpressure: none; en=0 freezes sampling, debounce and outputs.
// Ports: clk, rst (sync, active-high), bus (slave modport: h, en in; code, y, valid,
// blank, err, changed out). Optional macro SEG7_DEC_ERRCNT_EN adds bus.err_cnt[7:0].
module seg7_decode_onehot #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  seg7_decode_onehot_if.slave bus
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  // Blank pattern in the wire polarity of the board.
  localparam logic [6:0] BLANK_PAT = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {S_BLANK, S_DIGIT, S_FAULT} state_t;

  logic [6:0]    h_q, h_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [7:0]    y_q, y_d;
  logic          valid_q, valid_d;
  logic          blank_q, blank_d;
  logic          err_q, err_d;
  logic          changed_q, changed_d;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0]    err_cnt_q, err_cnt_d;
`endif

  logic       same;
  logic       commit;
  logic [6:0] pat_al;   // h_q normalised to active-low encoding
  logic       is_digit;
  logic       is_blank;
  logic [2:0] digit_val;

  // Decoder table is written in active-low form; flip the sample if the board is active-high.
  always_comb begin
    pat_al    = ACTIVE_LOW ? h_q : ~h_q;
    is_digit  = 1'b1;
    is_blank  = 1'b0;
    digit_val = 3'd0;
    case (pat_al)
      7'b1000000: digit_val = 3'd0;
      7'b1111001: digit_val = 3'd1;
      7'b0100100: digit_val = 3'd2;
      7'b0110000: digit_val = 3'd3;
      7'b0011001: digit_val = 3'd4;
      7'b0010010: digit_val = 3'd5;
      7'b0000010: digit_val = 3'd6;
      7'b1111000: digit_val = 3'd7;
      7'b1111111: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default:    is_digit = 1'b0;
    endcase
  end

  always_comb begin
    h_d       = h_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    code_d    = code_q;
    changed_d = 1'b0;
    same      = (bus.h == h_q);
    // Commit needs the current sample to match too, so a glitch arriving on the
    // saturating edge still blocks the update.
    commit    = bus.en && (cnt_q == CNT_MAX) && same;

    if (bus.en) begin
      h_d = bus.h;
      if (!same)                 cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    if (commit) begin
      if (is_digit) begin
        state_d = S_DIGIT;
        code_d  = digit_val;
      end else if (is_blank) begin
        state_d = S_BLANK;
      end else begin
        state_d = S_FAULT;
      end
      changed_d = (state_d != state_q) || (code_d != code_q);
    end

    valid_d = (state_d == S_DIGIT);
    blank_d = (state_d == S_BLANK);
    err_d   = (state_d == S_FAULT);
    y_d     = valid_d ? (8'b1 << code_d) : 8'h00;
  end

`ifdef SEG7_DEC_ERRCNT_EN
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (commit && (state_d == S_FAULT) && (state_q != S_FAULT) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q       <= BLANK_PAT;
      cnt_q     <= '0;
      state_q   <= S_BLANK;
      code_q    <= 3'd0;
      y_q       <= 8'h00;
      valid_q   <= 1'b0;
      blank_q   <= 1'b1;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
`ifdef SEG7_DEC_ERRCNT_EN
      err_cnt_q <= 8'h00;
`endif
    end else begin
      h_q       <= h_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      code_q    <= code_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      changed_q <= changed_d;
`ifdef SEG7_DEC_ERRCNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign bus.code    = code_q;
  assign bus.y       = y_q;
  assign bus.valid   = valid_q;
  assign bus.blank   = blank_q;
  assign bus.err     = err_q;
  assign bus.changed = changed_q;
`ifdef SEG7_DEC_ERRCNT_EN
  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
